run_sequencer: RTL and testbench
================================

RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter MAX_LOOP_COUNT, default 3, number of DUT test loops per run (1..255).
REQ-002 SHALL have parameter STOP_AT_ERROR, default 1'b0, 1 = end run at first failing loop.
REQ-003 SHALL have parameter HEART_BEAT, default 1'b1, 1 = heartbeat output enabled.
REQ-004 SHALL have parameter HB_CYCLES, default 100, heartbeat half-period in clk cycles (1 us at SYS_PERIOD 10 ns).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1000, per-loop done watchdog in clk cycles (>= 2).
REQ-006 SHALL have port clk  input  1  system clock; one clock, reset is asynchronous and active-low.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port start_i  input  1  run request, sampled in IDLE only.
REQ-009 SHALL have port abort_i  input  1  terminate run, sampled in any non-IDLE state.
REQ-010 SHALL have port dut_start_o  output  1  one-cycle launch pulse to the DUT.
REQ-011 SHALL have port dut_done_i  input  1  DUT loop complete, single-cycle pulse.
REQ-012 SHALL have port dut_pass_i  input  1  loop verdict, valid only when dut_done_i = 1.
REQ-013 SHALL have port busy_o  output  1  high in every non-IDLE state.
REQ-014 SHALL have port loop_idx_o  output  8  index of current/last loop, 0-based.
REQ-015 SHALL have port err_cnt_o  output  8  failing loops this run, saturating at 255.
REQ-016 SHALL have port run_done_o  output  1  one-cycle pulse on run completion.
REQ-017 SHALL have port run_pass_o  output  1  level: last run finished with err_cnt_o = 0, no timeout, no abort.
REQ-018 SHALL have port timeout_o  output  1  level: last run ended by watchdog.
REQ-019 SHALL have port heartbeat_o  output  1  square wave, period 2*HB_CYCLES.

Function
REQ-020 SHALL implement FSM states IDLE, LAUNCH, WAIT, CHECK, FINISH.
REQ-021 IDLE -> LAUNCH when start_i = 1; SHALL clear loop_idx_o, err_cnt_o, run_pass_o, timeout_o on this transition.
REQ-022 LAUNCH SHALL last exactly one cycle, assert dut_start_o in that cycle, clear watchdog, go to WAIT.
REQ-023 WAIT SHALL increment watchdog each cycle; dut_done_i = 1 -> CHECK with dut_pass_i registered.
REQ-024 WAIT with watchdog reaching TIMEOUT_CYCLES-1 and no dut_done_i SHALL set timeout_o and go to FINISH; done wins if both in same cycle.
REQ-025 CHECK SHALL increment err_cnt_o (saturating) on registered fail, then: fail and STOP_AT_ERROR -> FINISH; loop_idx_o = MAX_LOOP_COUNT-1 -> FINISH; else loop_idx_o+1 and LAUNCH.
REQ-026 FINISH SHALL last one cycle, pulse run_done_o, set run_pass_o per REQ-017, return to IDLE.
REQ-027 abort_i = 1 in LAUNCH/WAIT/CHECK SHALL go to FINISH next cycle, run_pass_o = 0; abort has priority over done and timeout.
REQ-028 dut_done_i outside WAIT SHALL be ignored; start_i outside IDLE SHALL be ignored.
REQ-029 Launch-to-launch latency with immediate done SHALL be 3 cycles (LAUNCH, WAIT, CHECK).
REQ-030 heartbeat_o SHALL toggle every HB_CYCLES cycles free-running, independent of FSM; held 0 when HEART_BEAT = 0.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, all outputs 0, all counters 0, including mid-run; no run_done_o pulse on reset.

Structure
REQ-032 State enum type and default timing constants SHALL live in verif_pkg alongside existing NS/US/SYS_PERIOD/loop constants.
REQ-033 Heartbeat divider SHALL be a sub-module heartbeat_gen (params HB_CYCLES, ENABLE).

Verification
REQ-034 MAX_LOOP_COUNT=3, done+pass 2 cycles after each dut_start_o -> 3 dut_start_o pulses, run_done_o once, run_pass_o=1, err_cnt_o=0, loop_idx_o=2.
REQ-035 STOP_AT_ERROR=1, loop 1 fails -> 2 dut_start_o pulses, err_cnt_o=1, loop_idx_o=1, run_pass_o=0.
REQ-036 STOP_AT_ERROR=0, loops 0 and 2 fail -> 3 launches, err_cnt_o=2, run_pass_o=0.
REQ-037 TIMEOUT_CYCLES=10, no done -> timeout_o=1 and run_done_o exactly 11 cycles after dut_start_o; done on cycle 10 instead -> no timeout.
REQ-038 abort_i in WAIT of loop 1 -> run_done_o next+1 cycle, run_pass_o=0; rst_n low mid-WAIT -> all outputs 0 immediately, start_i afterward runs normally.
REQ-039 HB_CYCLES=4 -> heartbeat_o period 8 cycles from reset; HEART_BEAT=0 -> constant 0.

Source files
------------

// File: rtl/verif_pkg.sv
// Shared verification-infrastructure constants and types for the run sequencer.
package verif_pkg;

  // Time base: SYS_PERIOD is the system clock period in NS units.
  localparam int NS                 = 1;
  localparam int US                 = 1000 * NS;
  localparam int SYS_PERIOD         = 10 * NS;

  // Loop and timing defaults.
  localparam int DEF_MAX_LOOP_COUNT = 3;
  localparam int DEF_HB_CYCLES      = US / SYS_PERIOD;
  localparam int DEF_TIMEOUT_CYCLES = 1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_CHECK,
    ST_FINISH
  } seq_state_e;

  // 8-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/heartbeat_gen.sv
// Free-running square-wave divider: toggles every HB_CYCLES clocks.
module heartbeat_gen
  import verif_pkg::*;
#(
  parameter int HB_CYCLES = DEF_HB_CYCLES,
  parameter bit ENABLE    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  output logic heartbeat_o
);

  localparam int CW = (HB_CYCLES > 1) ? $clog2(HB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HB_CYCLES - 1);

  generate
    if (ENABLE) begin : g_en
      logic [CW-1:0] cnt;
      // Count HB_CYCLES clocks, flip the output on the last one.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt         <= '0;
          heartbeat_o <= 1'b0;
        end else if (cnt == LAST) begin
          cnt         <= '0;
          heartbeat_o <= ~heartbeat_o;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end else begin : g_dis
      assign heartbeat_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/run_sequencer.sv
// Run sequencer: launches MAX_LOOP_COUNT DUT loops, collects verdicts,
// guards each loop with a done watchdog and reports a run-level result.
module run_sequencer
  import verif_pkg::*;
#(
  parameter int MAX_LOOP_COUNT = DEF_MAX_LOOP_COUNT,
  parameter bit STOP_AT_ERROR  = 1'b0,
  parameter bit HEART_BEAT     = 1'b1,
  parameter int HB_CYCLES      = DEF_HB_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       dut_start_o,
  input  logic       dut_done_i,
  input  logic       dut_pass_i,
  output logic       busy_o,
  output logic [7:0] loop_idx_o,
  output logic [7:0] err_cnt_o,
  output logic       run_done_o,
  output logic       run_pass_o,
  output logic       timeout_o,
  output logic       heartbeat_o
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] LAST_WD  = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     LAST_IDX = 8'(MAX_LOOP_COUNT - 1);

  seq_state_e     state;
  logic [WDW-1:0] wd;
  logic           pass_q;
  logic [7:0]     err_nxt;

  // Error count as it will stand after the loop in CHECK is accounted.
  always_comb begin
    err_nxt = pass_q ? err_cnt_o : sat_inc8(err_cnt_o);
  end

  // Sequencer FSM; every output is a register updated on the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wd          <= '0;
      pass_q      <= 1'b0;
      dut_start_o <= 1'b0;
      busy_o      <= 1'b0;
      loop_idx_o  <= '0;
      err_cnt_o   <= '0;
      run_done_o  <= 1'b0;
      run_pass_o  <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      dut_start_o <= 1'b0;
      run_done_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state       <= ST_LAUNCH;
            dut_start_o <= 1'b1;
            busy_o      <= 1'b1;
            loop_idx_o  <= '0;
            err_cnt_o   <= '0;
            run_pass_o  <= 1'b0;
            timeout_o   <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          wd <= '0;
          if (abort_i) begin
            state      <= ST_FINISH;
            run_done_o <= 1'b1;
            run_pass_o <= 1'b0;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Abort beats done, done beats the watchdog.
          if (abort_i) begin
            state      <= ST_FINISH;
            run_done_o <= 1'b1;
            run_pass_o <= 1'b0;
          end else if (dut_done_i) begin
            state  <= ST_CHECK;
            pass_q <= dut_pass_i;
          end else if (wd == LAST_WD) begin
            state      <= ST_FINISH;
            timeout_o  <= 1'b1;
            run_done_o <= 1'b1;
            run_pass_o <= 1'b0;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ST_CHECK: begin
          if (abort_i) begin
            state      <= ST_FINISH;
            run_done_o <= 1'b1;
            run_pass_o <= 1'b0;
          end else begin
            err_cnt_o <= err_nxt;
            if ((!pass_q && STOP_AT_ERROR) || (loop_idx_o == LAST_IDX)) begin
              state      <= ST_FINISH;
              run_done_o <= 1'b1;
              run_pass_o <= (err_nxt == 8'd0);
            end else begin
              state       <= ST_LAUNCH;
              dut_start_o <= 1'b1;
              loop_idx_o  <= loop_idx_o + 8'd1;
            end
          end
        end
        ST_FINISH: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  heartbeat_gen #(
    .HB_CYCLES (HB_CYCLES),
    .ENABLE    (HEART_BEAT)
  ) u_hb (
    .clk         (clk),
    .rst_n       (rst_n),
    .heartbeat_o (heartbeat_o)
  );

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: two instances (continue-on-error with
// heartbeat, stop-at-error without), a behavioural DUT responder and a
// scoreboard of expected run results checked on each run_done_o.
module tb_run_sequencer;

  typedef struct {
    bit         pass;
    logic [7:0] err;
    logic [7:0] idx;
    bit         tmo;
    int         launches;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [2];
  logic       abort [2];
  logic       done  [2];
  logic       pass  [2];
  logic       dstart[2];
  logic       busy  [2];
  logic [7:0] idx   [2];
  logic [7:0] err   [2];
  logic       rdone [2];
  logic       rpass [2];
  logic       tmo   [2];
  logic       hb    [2];

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  run_sequencer #(
    .MAX_LOOP_COUNT(3), .STOP_AT_ERROR(1'b0), .HEART_BEAT(1'b1),
    .HB_CYCLES(4), .TIMEOUT_CYCLES(10)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .abort_i(abort[0]),
    .dut_start_o(dstart[0]), .dut_done_i(done[0]), .dut_pass_i(pass[0]),
    .busy_o(busy[0]), .loop_idx_o(idx[0]), .err_cnt_o(err[0]),
    .run_done_o(rdone[0]), .run_pass_o(rpass[0]), .timeout_o(tmo[0]),
    .heartbeat_o(hb[0])
  );

  run_sequencer #(
    .MAX_LOOP_COUNT(3), .STOP_AT_ERROR(1'b1), .HEART_BEAT(1'b0),
    .HB_CYCLES(4), .TIMEOUT_CYCLES(10)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .abort_i(abort[1]),
    .dut_start_o(dstart[1]), .dut_done_i(done[1]), .dut_pass_i(pass[1]),
    .busy_o(busy[1]), .loop_idx_o(idx[1]), .err_cnt_o(err[1]),
    .run_done_o(rdone[1]), .run_pass_o(rpass[1]), .timeout_o(tmo[1]),
    .heartbeat_o(hb[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int d, input string pfx);
    chk({pfx, "_dut_start"}, dstart[d], 0);
    chk({pfx, "_busy"},      busy[d],   0);
    chk({pfx, "_loop_idx"},  idx[d],    0);
    chk({pfx, "_err_cnt"},   err[d],    0);
    chk({pfx, "_run_done"},  rdone[d],  0);
    chk({pfx, "_run_pass"},  rpass[d],  0);
    chk({pfx, "_timeout"},   tmo[d],    0);
    chk({pfx, "_heartbeat"}, hb[d],     0);
  endtask

  // One run on instance d. The responder answers each launch dly cycles
  // later with verdict ~fmask[loop]; loop 'hang' never answers; 'abrt'
  // aborts two cycles after that loop's launch; 'rstl' pulls reset there.
  task automatic do_run(input int d, input int dly, input logic [7:0] fmask,
                        input int hang, input int abrt, input int rstl,
                        input bit hold, input exp_t e);
    int   cyc, launches, last_l, tgt;
    bit   pending, fin;
    exp_t g;
    if (rstl < 0) exp_q.push_back(e);
    start[d] = 1'b1;
    cyc = 0; launches = 0; last_l = 0; tgt = 0; pending = 0; fin = 0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!hold) start[d] = 1'b0;
      done[d]  = 1'b0;
      abort[d] = 1'b0;
      if (dstart[d]) begin
        launches++;
        if (launches > 1) chk("launch_spacing", cyc - last_l, dly + 2);
        last_l  = cyc;
        pending = (hang != launches - 1);
        tgt     = cyc + dly;
      end
      if (rstl >= 0 && rstl == launches - 1 && cyc == last_l + 2) begin
        chk("pre_rst_busy", busy[d], 1);
        chk("pre_rst_err",  err[d],  1);
        chk("pre_rst_idx",  idx[d],  1);
        rst_n = 1'b0;
        #1;
        chk_zero(d, "mid_rst");
        @(negedge clk);
        chk("rst_no_run_done", rdone[d], 0);
        rst_n = 1'b1;
        fin = 1;
      end else begin
        if (pending && cyc == tgt) begin
          done[d] = 1'b1;
          pass[d] = ~fmask[launches - 1];
          pending = 0;
        end
        if (abrt >= 0 && abrt == launches - 1 && cyc == last_l + 2) abort[d] = 1'b1;
        if (rdone[d]) begin
          fin      = 1;
          start[d] = 1'b0;
          done[d]  = 1'b0;
          abort[d] = 1'b0;
          if (exp_q.size() == 0) begin
            chk("sb_underflow", exp_q.size(), 1);
          end else begin
            g = exp_q.pop_front();
            chk("run_pass",   rpass[d],      g.pass);
            chk("err_cnt",    err[d],        g.err);
            chk("loop_idx",   idx[d],        g.idx);
            chk("timeout",    tmo[d],        g.tmo);
            chk("launches",   launches,      g.launches);
            chk("done_lat",   cyc - last_l,  g.lat);
            chk("busy_fin",   busy[d],       1);
            @(negedge clk);
            chk("run_done_pulse", rdone[d], 0);
            chk("busy_idle",      busy[d],  0);
            chk("pass_level",     rpass[d], g.pass);
          end
        end
      end
    end
    chk("run_bound", fin, 1);
    start[d] = 1'b0;
    done[d]  = 1'b0;
    abort[d] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; done[i] = 1'b0; pass[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    rst_n = 1'b1;

    // Heartbeat: low for 4 clocks after release, then 8-cycle period.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("hb_on",  hb[0], (k / 4) % 2);
      chk("hb_off", hb[1], 0);
    end

    // Stray done/abort in IDLE must not start anything.
    done[0] = 1'b1; pass[0] = 1'b1; abort[0] = 1'b1;
    @(negedge clk);
    done[0] = 1'b0; abort[0] = 1'b0;
    chk("idle_stray_busy",   busy[0],   0);
    chk("idle_stray_launch", dstart[0], 0);
    @(negedge clk);
    chk("idle_stray_busy2",  busy[0],   0);

    //     d  dly fmask hang abrt rstl hold   pass err   idx   tmo L lat
    do_run(0, 2, 8'h00, -1, -1, -1, 1'b1, '{1'b1, 8'd0, 8'd2, 1'b0, 3, 4});
    do_run(1, 2, 8'h02, -1, -1, -1, 1'b0, '{1'b0, 8'd1, 8'd1, 1'b0, 2, 4});
    do_run(0, 2, 8'h05, -1, -1, -1, 1'b0, '{1'b0, 8'd2, 8'd2, 1'b0, 3, 4});
    do_run(0, 1, 8'h00, -1, -1, -1, 1'b0, '{1'b1, 8'd0, 8'd2, 1'b0, 3, 3});
    do_run(0, 2, 8'h00,  0, -1, -1, 1'b0, '{1'b0, 8'd0, 8'd0, 1'b1, 1, 11});
    do_run(0, 10, 8'h00, -1, -1, -1, 1'b0, '{1'b1, 8'd0, 8'd2, 1'b0, 3, 12});
    do_run(0, 2, 8'h00, -1,  1, -1, 1'b0, '{1'b0, 8'd0, 8'd1, 1'b0, 2, 3});
    do_run(0, 2, 8'h01, -1, -1,  1, 1'b0, '{1'b0, 8'd0, 8'd0, 1'b0, 0, 0});
    do_run(0, 3, 8'h00, -1, -1, -1, 1'b0, '{1'b1, 8'd0, 8'd2, 1'b0, 3, 5});
    do_run(1, 2, 8'h00, -1, -1, -1, 1'b0, '{1'b1, 8'd0, 8'd2, 1'b0, 3, 4});

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
